inv_sub_bytes_seq: RTL and testbench

//  Iterative AES InvSubBytes engine for the decryption datapath; the inverse of the forward S-box byte substitution.

---
 rtl/inv_sub_bytes_seq.sv | 133 +++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes: BPC inverse S-box lookups per clock.
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready/in_state,
// out_valid/out_ready/out_state (byte 0 = [127:120]), busy.
module inv_sub_bytes_seq #(
  parameter int BPC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int N  = 16 / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!(BPC == 1 || BPC == 2 || BPC == 4 ||
        BPC == 8 || BPC == 16)) begin : g_bad_bpc
    $error("BPC must be 1, 2, 4, 8 or 16");
  end

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } st_t;

  st_t           st_q;
  logic [CW-1:0] cnt_q;
  logic [127:0]  data_q;
  logic [127:0]  data_d;
  logic          rdy_q;
  logic          vld_q;
  logic          busy_q;

  // Substitute chunk cnt_q in place; other bytes pass through.
  always_comb begin
    data_d = data_q;
    for (int j = 0; j < BPC; j++) begin
      data_d[127 - 8*(int'(cnt_q)*BPC + j) -: 8] =
        INV_SBOX[data_q[127 - 8*(int'(cnt_q)*BPC + j) -: 8]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      data_q <= '0;
      rdy_q  <= 1'b0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (in_valid && rdy_q) begin
            data_q <= in_state;
            cnt_q  <= '0;
            st_q   <= BUSY;
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
          end else begin
            rdy_q  <= 1'b1;
          end
        end
        BUSY: begin
          data_q <= data_d;
          if (cnt_q == CW'(N - 1)) begin
            cnt_q  <= '0;
            st_q   <= DONE;
            busy_q <= 1'b0;
            vld_q  <= 1'b1;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            st_q  <= IDLE;
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_state = data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq across BPC = 1,2,4,8,16.
// Model: GF(2^8) forward S-box, inverted into a lookup table.
module tb_inv_sub_bytes_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_done = 0;

  logic [7:0] fwd_tbl [256];
  logic [7:0] inv_tbl [256];

  task automatic chk(input string nm, input int bpc,
                     input logic [131:0] a,
                     input logic [131:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s bpc=%0d got=%h want=%h",
                  nm, bpc, a, e);
  endtask

  task automatic to_fail(input string nm, input int bpc);
    n_chk++;
    $display("FAIL %s bpc=%0d got=timeout want=handshake",
             nm, bpc);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a0,
                                      input logic [7:0] b0);
    logic [7:0] p, a, b;
    p = 8'h00; a = a0; b = b0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b,
                                      input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = inv_tbl[s[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [7:0] iv, s;
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3)
             ^ rotl(iv, 4) ^ 8'h63;
      fwd_tbl[x] = s;
      inv_tbl[s] = 8'(x);
    end
    chk("model_63", 0, 132'(inv_tbl[8'h63]), 132'h00);
    chk("model_7c", 0, 132'(inv_tbl[8'h7c]), 132'h01);
    chk("model_00", 0, 132'(inv_tbl[8'h00]), 132'h52);
    chk("model_16", 0, 132'(inv_tbl[8'h16]), 132'hff);
    chk("model_52", 0, 132'(inv_tbl[8'h52]), 132'h48);
  end

  localparam logic [127:0] V2  =
    128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] E2  =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SPI =
    128'h0016637c52_0000000000_0000000000_00;
  localparam logic [127:0] SPE =
    128'h52ff000148_5252525252_5252525252_52;

  for (genvar g = 0; g < 5; g++) begin : u
    localparam int B = 1 << g;
    localparam int N = 16 / B;

    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    inv_sub_bytes_seq #(.BPC(B)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy)
    );

    logic [127:0] q [$];
    int cyc = 0;
    int acc_cyc = 0;
    int last_acc = -1;
    int n_acc = 0;
    int n_rx = 0;
    bit lat_open = 0;
    bit prev_low = 0;
    bit prev_hs = 0;
    bit b2b = 0;
    bit sdone = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
      if (!rst_n) begin
        if (prev_low)
          chk("rst_out", B,
              {1'b0, in_ready, out_valid, busy, out_state}, '0);
        q.delete();
        lat_open = 0;
        prev_hs  = 0;
      end else begin
        if (prev_hs)
          chk("rdy_after_hs", B,
              132'({in_ready, out_valid}), 132'b10);
        prev_hs = 0;
        if (out_valid) begin
          chk("valid_pending", B,
              132'(q.size() != 0), 132'(1));
          if (q.size() != 0) begin
            chk("out_state", B, 132'(out_state), 132'(q[0]));
            chk("flags_done", B,
                132'({in_ready, busy}), 132'b00);
            if (lat_open)
              chk("latency", B, 132'(cyc - acc_cyc), 132'(N + 1));
            lat_open = 0;
            if (out_ready) begin
              void'(q.pop_front());
              n_rx++;
              prev_hs = 1;
            end
          end
        end else if (q.size() != 0) begin
          chk("flags_busy", B,
              132'({in_ready, busy}), 132'b01);
        end
        if (in_valid && in_ready) begin
          q.push_back(model(in_state));
          n_acc++;
          if (b2b && last_acc >= 0)
            chk("throughput", B,
                132'(cyc - last_acc), 132'(N + 2));
          last_acc = cyc;
          acc_cyc  = cyc;
          lat_open = 1;
        end
      end
      prev_low = !rst_n;
    end

    task automatic send(input logic [127:0] s);
      bit ok;
      ok = 0;
      in_state = s;
      in_valid = 1'b1;
      for (int t = 0; t < 400; t++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (!ok) to_fail("send", B);
    endtask

    task automatic wait_out(output logic [127:0] got);
      bit ok;
      ok = 0;
      got = '0;
      for (int t = 0; t < 400; t++) begin
        @(negedge clk);
        if (out_valid) begin ok = 1; break; end
      end
      got = out_state;
      @(posedge clk); #1;
      if (!ok) to_fail("wait_out", B);
    endtask

    task automatic drain();
      for (int t = 0; t < 4000 && q.size() != 0; t++)
        @(negedge clk);
      if (q.size() != 0) to_fail("drain", B);
      @(posedge clk); #1;
    endtask

    initial begin
      logic [127:0] got, s, e;
      int a0, r0;
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_state  = rnd();
      out_ready = 1'b0;
      @(posedge clk);
      repeat (2) begin
        @(negedge clk);
        chk("rst_hold", B,
            {1'b0, in_ready, out_valid, busy, out_state}, '0);
      end
      @(posedge clk); #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rdy_release", B, 132'(in_ready), 132'(1));
      @(posedge clk); #1;

      out_ready = 1'b1;
      send(V2);
      wait_out(got);
      chk("vec2", B, 132'(got), 132'(E2));

      for (int k = 0; k < 16; k++) begin
        for (int i = 0; i < 16; i++) begin
          s[127-8*i -: 8] = fwd_tbl[16*k + i];
          e[127-8*i -: 8] = 8'(16*k + i);
        end
        send(s);
        wait_out(got);
        chk("table", B, 132'(got), 132'(e));
      end
      send(SPI);
      wait_out(got);
      chk("spot", B, 132'(got), 132'(SPE));

      out_ready = 1'b0;
      send({16{8'h16}});
      wait_out(got);
      repeat (10) begin
        @(negedge clk);
        chk("bp_hold", B,
            {2'b00, out_valid, in_ready, out_state},
            {2'b00, 1'b1, 1'b0, {16{8'hff}}});
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release", B,
          132'({in_ready, out_valid}), 132'b10);
      @(posedge clk); #1;

      send(rnd());
      repeat ((N > 2) ? 2 : 0) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (N + 4) begin
        @(negedge clk);
        chk("abort_no_valid", B, 132'(out_valid), 132'(0));
      end
      @(posedge clk); #1;
      send({16{8'h63}});
      wait_out(got);
      chk("after_abort", B, 132'(got), 132'(0));

      b2b      = 1;
      last_acc = -1;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
        in_state = rnd();
        for (int t = 0; t < 400; t++) begin
          @(negedge clk);
          if (in_ready) break;
        end
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      drain();
      b2b = 0;

      a0 = n_acc;
      r0 = n_rx;
      fork
        begin
          for (int i = 0; i < 20; i++) begin
            in_state = rnd();
            for (int t = 0; t < 2000; t++) begin
              bit acc;
              in_valid = 1'($urandom % 2);
              @(negedge clk);
              acc = in_valid && in_ready;
              @(posedge clk); #1;
              if (acc) break;
            end
          end
          in_valid = 1'b0;
          sdone = 1;
        end
        begin
          while (!sdone) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom % 2);
          end
        end
      join
      out_ready = 1'b1;
      drain();
      chk("rand_sent", B, 132'(n_acc - a0), 132'(20));
      chk("lossless", B, 132'(n_rx - r0), 132'(n_acc - a0));
      n_done++;
    end
  end

  initial begin
    for (int t = 0; t < 60000; t++) begin
      @(posedge clk);
      if (n_done == 5) break;
    end
    if (n_done != 5) to_fail("global", 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
